// File: rtl/add_nibble_seq_if.sv
// Operand/result handshake bundle for add_nibble_seq.
// slave is the adder's view; master is the producer/consumer's view.
interface add_nibble_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/add_nibble_seq.sv
// Multi-cycle WIDTH-bit adder: one 4-bit lookahead slice per cycle, LS nibble first,
// with the carry held in a register between slices.
module add_nibble_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  add_nibble_seq_if.slave  bus,
  output logic             busy
);
  localparam int unsigned NNIB = WIDTH / 4;
  localparam int unsigned CW   = (NNIB > 1) ? $clog2(NNIB) : 1;

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("add_nibble_seq: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [3:0]       g, p, c;
  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH+3:0] sum_cat;

  // 4-bit carry-lookahead slice on the low nibble of the shift registers
  always_comb begin
    g          = a_sh_q[3:0] & b_sh_q[3:0];
    p          = a_sh_q[3:0] ^ b_sh_q[3:0];
    c[0]       = carry_q;
    c[1]       = g[0] | (p[0] & c[0]);
    c[2]       = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]       = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    slice_cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);
    slice_sum  = p ^ c;
  end

  // Concatenate-then-slice keeps the shift legal when WIDTH==4
  assign sum_cat = {slice_sum, sum_sh_q};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_sh_d = sum_cat[WIDTH+3:4];
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        carry_d  = slice_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(NNIB - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_sh_q;
  assign bus.cout      = carry_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_add_nibble_seq.sv
// Bench for add_nibble_seq at WIDTH=32 and WIDTH=4 against a plain a+b+cin model.
module tb_add_nibble_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy32, busy4;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [32:0] q32[$];
  logic [4:0]  q4[$];

  always #5 clk = ~clk;

  add_nibble_seq_if #(.WIDTH(32)) b32();
  add_nibble_seq_if #(.WIDTH(4))  b4();

  add_nibble_seq #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32), .busy(busy32));
  add_nibble_seq #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(b4),  .busy(busy4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    vectors++;
    if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0 || b32.sum !== 32'h0 ||
        b32.cout !== 1'b0 || busy32 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset32: in_ready=%b out_valid=%b sum=%h cout=%b busy=%b, required 1 0 0 0 0",
               b32.in_ready, b32.out_valid, b32.sum, b32.cout, busy32);
    end
    vectors++;
    if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0 || b4.sum !== 4'h0 ||
        b4.cout !== 1'b0 || busy4 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset4: in_ready=%b out_valid=%b sum=%h cout=%b busy=%b, required 1 0 0 0 0",
               b4.in_ready, b4.out_valid, b4.sum, b4.cout, busy4);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One op with out_ready held high: checks latency, result, single-cycle valid, ready return
  task automatic run_op32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input string name);
    logic [32:0] exp;
    int unsigned lat;
    exp = {1'b0, a} + {1'b0, b} + {32'h0, cin};
    lat = 0;
    while (!b32.in_ready && lat < 40) begin tick(); lat++; end
    b32.out_ready = 1'b1;
    b32.in_valid = 1'b1; b32.a = a; b32.b = b; b32.cin = cin;
    tick();
    b32.in_valid = 1'b0; b32.a = $urandom; b32.b = $urandom; b32.cin = ~cin;
    lat = 0;
    while (!b32.out_valid && lat < 40) begin tick(); lat++; end
    vectors++;
    if (lat != 8) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles, required 8", name, lat);
    end
    vectors++;
    if ({b32.cout, b32.sum} !== exp) begin
      miscompares++;
      $display("FAIL %s_result: got cout=%b sum=%h, required cout=%b sum=%h",
               name, b32.cout, b32.sum, exp[32], exp[31:0]);
    end
    tick();
    vectors++;
    if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1 || busy32 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_return: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
               name, b32.out_valid, b32.in_ready, busy32);
    end
  endtask

  task automatic test_directed;
    run_op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "wrap");
    run_op32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "mixed");
    run_op32(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, "cin_ripple");
  endtask

  task automatic test_width4;
    int unsigned lat;
    b4.out_ready = 1'b1;
    b4.in_valid = 1'b1; b4.a = 4'hF; b4.b = 4'h1; b4.cin = 1'b0;
    tick();
    b4.in_valid = 1'b0;
    lat = 0;
    while (!b4.out_valid && lat < 20) begin tick(); lat++; end
    vectors++;
    if (lat != 1 || {b4.cout, b4.sum} !== 5'h10) begin
      miscompares++;
      $display("FAIL w4_wrap: latency=%0d cout=%b sum=%h, required latency=1 cout=1 sum=0",
               lat, b4.cout, b4.sum);
    end
    tick();
  endtask

  task automatic test_backpressure;
    logic [32:0] exp1, exp2;
    int unsigned lat;
    exp1 = {1'b0, 32'hDEAD_BEEF} + {1'b0, 32'h1111_2222} + 33'd1;
    exp2 = {1'b0, 32'h0F0F_0F0F} + {1'b0, 32'hF0F0_F0F1} + 33'd0;
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1; b32.a = 32'hDEAD_BEEF; b32.b = 32'h1111_2222; b32.cin = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    lat = 0;
    while (!b32.out_valid && lat < 40) begin tick(); lat++; end
    b32.in_valid = 1'b1; b32.a = 32'h0F0F_0F0F; b32.b = 32'hF0F0_F0F1; b32.cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (b32.out_valid !== 1'b1 || b32.in_ready !== 1'b0 || {b32.cout, b32.sum} !== exp1) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b cout=%b sum=%h, required 1 0 %b %h",
                 i, b32.out_valid, b32.in_ready, b32.cout, b32.sum, exp1[32], exp1[31:0]);
      end
      tick();
    end
    b32.out_ready = 1'b1;
    tick();
    vectors++;
    if (b32.in_ready !== 1'b1 || busy32 !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_release: in_ready=%b busy=%b, required 1 0", b32.in_ready, busy32);
    end
    tick();
    b32.in_valid = 1'b0;
    lat = 0;
    while (!b32.out_valid && lat < 40) begin tick(); lat++; end
    vectors++;
    if (lat != 8 || {b32.cout, b32.sum} !== exp2) begin
      miscompares++;
      $display("FAIL stall_next: latency=%0d cout=%b sum=%h, required 8 %b %h",
               lat, b32.cout, b32.sum, exp2[32], exp2[31:0]);
    end
    tick();
  endtask

  task automatic test_reset_mid_run;
    logic seen_valid;
    seen_valid = 1'b0;
    b32.out_ready = 1'b1;
    b32.in_valid = 1'b1; b32.a = 32'hAAAA_5555; b32.b = 32'h5555_AAAA; b32.cin = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1 || b32.sum !== 32'h0 ||
        b32.cout !== 1'b0 || busy32 !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset: out_valid=%b in_ready=%b sum=%h cout=%b busy=%b, required 0 1 0 0 0",
               b32.out_valid, b32.in_ready, b32.sum, b32.cout, busy32);
    end
    for (int i = 0; i < 12; i++) begin
      if (i == 2) rst_n = 1'b1;
      if (b32.out_valid) seen_valid = 1'b1;
      tick();
    end
    vectors++;
    if (seen_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_no_valid: out_valid pulsed=%b, required 0", seen_valid);
    end
    run_op32(32'd1, 32'd2, 1'b0, "after_reset");
  endtask

  task automatic test_random;
    int unsigned iss32, iss4, done32, done4, cyc;
    logic [32:0] e32;
    logic [4:0]  e4;
    iss32 = 0; iss4 = 0; done32 = 0; done4 = 0; cyc = 0;
    q32.delete(); q4.delete();
    while ((done32 < 1000 || done4 < 1000) && cyc < 60000) begin
      b32.out_ready = ($urandom_range(0, 3) != 0);
      if (b32.out_valid && b32.out_ready) begin
        vectors++;
        if (q32.size() == 0) begin
          miscompares++;
          $display("FAIL rand32_extra: unexpected result sum=%h", b32.sum);
        end else begin
          e32 = q32.pop_front();
          if ({b32.cout, b32.sum} !== e32) begin
            miscompares++;
            $display("FAIL rand32: got cout=%b sum=%h, required cout=%b sum=%h",
                     b32.cout, b32.sum, e32[32], e32[31:0]);
          end
        end
        done32++;
      end
      b32.in_valid = (iss32 < 1000) && ($urandom_range(0, 4) != 0);
      b32.a = $urandom; b32.b = $urandom; b32.cin = 1'($urandom_range(0, 1));
      if (b32.in_valid && b32.in_ready) begin
        q32.push_back({1'b0, b32.a} + {1'b0, b32.b} + {32'h0, b32.cin});
        iss32++;
      end

      b4.out_ready = ($urandom_range(0, 3) != 0);
      if (b4.out_valid && b4.out_ready) begin
        vectors++;
        if (q4.size() == 0) begin
          miscompares++;
          $display("FAIL rand4_extra: unexpected result sum=%h", b4.sum);
        end else begin
          e4 = q4.pop_front();
          if ({b4.cout, b4.sum} !== e4) begin
            miscompares++;
            $display("FAIL rand4: got cout=%b sum=%h, required cout=%b sum=%h",
                     b4.cout, b4.sum, e4[4], e4[3:0]);
          end
        end
        done4++;
      end
      b4.in_valid = (iss4 < 1000) && ($urandom_range(0, 4) != 0);
      b4.a = 4'($urandom); b4.b = 4'($urandom); b4.cin = 1'($urandom_range(0, 1));
      if (b4.in_valid && b4.in_ready) begin
        q4.push_back({1'b0, b4.a} + {1'b0, b4.b} + {4'h0, b4.cin});
        iss4++;
      end
      tick();
      cyc++;
    end
    b32.in_valid = 1'b0; b4.in_valid = 1'b0;
    vectors++;
    if (done32 != 1000 || done4 != 1000 || q32.size() != 0 || q4.size() != 0) begin
      miscompares++;
      $display("FAIL rand_count: done32=%0d done4=%0d pending32=%0d pending4=%0d, required 1000 1000 0 0",
               done32, done4, q32.size(), q4.size());
    end
  endtask

  initial begin
    b32.in_valid = 1'b0; b32.a = '0; b32.b = '0; b32.cin = 1'b0; b32.out_ready = 1'b0;
    b4.in_valid = 1'b0;  b4.a = '0;  b4.b = '0;  b4.cin = 1'b0;  b4.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_width4();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
